// File: rtl/sweep_capture_ctrl.sv
// rtl/sweep_capture_ctrl.sv - radar sweep capture sequencer
// Windows and decimates packed range-bin words per sweep, prefixing captures with a header word.
module sweep_capture_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16,
  parameter int AZ_W   = 12,
  parameter int DEC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trg,
  input  logic              hm,
  input  logic              bi,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  input  logic [CNT_W-1:0]  cfg_start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [DEC_W-1:0]  cfg_decim,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  sweep_cnt,
  output logic [7:0]        trunc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRG, S_CAPTURE, S_SKIP} state_t;

  state_t            state;
  logic              trg_q, hm_q, bi_q;
  logic [AZ_W-1:0]   az;
  logic [AZ_W-1:0]   az_next;
  logic [DEC_W-1:0]  dec_cnt;
  logic [CNT_W-1:0]  bin;
  logic [CNT_W-1:0]  sh_start;
  logic [CNT_W-1:0]  sh_len;
  logic [CNT_W:0]    win_end;
  logic [CNT_W:0]    bin_ext;
  logic              in_win;
  logic              win_last;
  logic              trg_edge, hm_edge, bi_edge;
  logic              trg_fire;
  logic [CNT_W-1:0]  sweep_next;
  logic [WORD_W-1:0] hdr_word;

  assign trg_edge = trg & ~trg_q;
  assign hm_edge  = hm & ~hm_q;
  assign bi_edge  = bi & ~bi_q;

  // Heading marker beats a simultaneous bearing increment.
  always_comb begin
    az_next = az;
    if (hm_edge)
      az_next = '0;
    else if (bi_edge)
      az_next = az + 1'b1;
  end

  // Window end is one bit wider so start+len never wraps.
  assign win_end  = {1'b0, sh_start} + {1'b0, sh_len};
  assign bin_ext  = {1'b0, bin};
  assign in_win   = (bin >= sh_start) && (bin_ext < win_end);
  assign win_last = (bin_ext + 1'b1) == win_end;

  assign sweep_next = sweep_cnt + 1'b1;
  assign hdr_word   = WORD_W'({4'hA, az_next, sweep_next});

  // A trigger in CAPTURE is an early trigger and is honoured regardless of arm.
  assign trg_fire = trg_edge &&
                    ((state == S_CAPTURE) ||
                     (((state == S_WAIT_TRG) || (state == S_SKIP)) && arm));

  assign busy = (state == S_CAPTURE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      trg_q     <= 1'b0;
      hm_q      <= 1'b0;
      bi_q      <= 1'b0;
      az        <= '0;
      dec_cnt   <= '0;
      bin       <= '0;
      sh_start  <= '0;
      sh_len    <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      sweep_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      trg_q     <= trg;
      hm_q      <= hm;
      bi_q      <= bi;
      az        <= az_next;
      out_valid <= 1'b0;

      if (trg_fire) begin
        if ((state == S_CAPTURE) && (trunc_cnt != 8'hFF))
          trunc_cnt <= trunc_cnt + 1'b1;
        sweep_cnt <= sweep_next;
        sh_start  <= cfg_start;
        sh_len    <= cfg_len;
        if (dec_cnt == '0) begin
          dec_cnt   <= cfg_decim;
          bin       <= '0;
          out_word  <= hdr_word;
          out_valid <= 1'b1;
          if (cfg_len == '0)
            state <= arm ? S_WAIT_TRG : S_IDLE;
          else
            state <= S_CAPTURE;
        end else begin
          dec_cnt <= dec_cnt - 1'b1;
          state   <= S_SKIP;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              sweep_cnt <= '0;
              trunc_cnt <= '0;
              dec_cnt   <= '0;
              state     <= S_WAIT_TRG;
            end
          end
          S_WAIT_TRG, S_SKIP: begin
            if (!arm)
              state <= S_IDLE;
          end
          S_CAPTURE: begin
            if (in_valid) begin
              bin <= bin + 1'b1;
              if (in_win) begin
                out_word  <= in_word;
                out_valid <= 1'b1;
                if (win_last)
                  state <= arm ? S_WAIT_TRG : S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_capture_ctrl.sv
// tb/tb_sweep_capture_ctrl.sv - self-checking bench for sweep_capture_ctrl
module tb_sweep_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, trg, hm, bi, in_valid;
  logic [31:0] in_word;
  logic [15:0] cfg_start, cfg_len;
  logic [7:0]  cfg_decim;
  logic [31:0] out_word;
  logic        out_valid, busy;
  logic [15:0] sweep_cnt;
  logic [7:0]  trunc_cnt;

  int checks = 0;
  int failures = 0;

  sweep_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trg(trg), .hm(hm), .bi(bi),
    .in_word(in_word), .in_valid(in_valid),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .out_word(out_word), .out_valid(out_valid), .busy(busy),
    .sweep_cnt(sweep_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        trg;
    logic        iv;
    logic [31:0] w;
    logic        ev;
    logic [31:0] ew;
    logic        eb;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic a, input logic t, input logic h, input logic b,
                     input logic v, input logic [31:0] w);
    arm = a; trg = t; hm = h; bi = b; in_valid = v; in_word = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input logic [11:0] az, input logic [15:0] s);
    return {4'hA, az, s};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; arm = 0; trg = 0; hm = 0; bi = 0; in_valid = 0; in_word = '0;
    cfg_start = 16'd3; cfg_len = 16'd4; cfg_decim = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_word", out_word, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sweep", {16'd0, sweep_cnt}, 32'd0);
    chk("rst_trunc", {24'd0, trunc_cnt}, 32'd0);
    rst_n = 1'b1;

    // Test 1: window 3..6 of ten words
    tbl[0] = '{trg:0, iv:0, w:32'd0, ev:0, ew:32'd0, eb:0};
    tbl[1] = '{trg:1, iv:0, w:32'd0, ev:1, ew:32'hA000_0001, eb:1};
    for (int i = 0; i < 10; i++) begin
      tbl[2+i].trg = 1'b0;
      tbl[2+i].iv  = 1'b1;
      tbl[2+i].w   = 32'hD000_0000 + i;
      tbl[2+i].ev  = (i >= 3 && i <= 6);
      tbl[2+i].ew  = 32'hD000_0000 + i;
      tbl[2+i].eb  = (i < 6);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tbl[i].trg, 1'b0, 1'b0, tbl[i].iv, tbl[i].w);
      chk($sformatf("t1_valid[%0d]", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev)
        chk($sformatf("t1_word[%0d]", i), out_word, tbl[i].ew);
      chk($sformatf("t1_busy[%0d]", i), {31'd0, busy}, {31'd0, tbl[i].eb});
    end

    // Test 2: decimation by 3
    cfg_decim = 8'd2; cfg_start = 16'd2; cfg_len = 16'd3;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 7; s++) begin
      logic cap;
      cap = (s == 1 || s == 4 || s == 7);
      cyc(1, 1, 0, 0, 0, 0);
      chk($sformatf("t2_hdr_valid[%0d]", s), {31'd0, out_valid}, {31'd0, cap});
      if (cap)
        chk($sformatf("t2_hdr[%0d]", s), out_word, hdr(12'd0, 16'(s)));
      n = 0;
      for (int k = 0; k < 8; k++) begin
        cyc(1, 0, 0, 0, 1, 32'h2000_0000 + k);
        if (out_valid) n++;
      end
      chk($sformatf("t2_count[%0d]", s), n, cap ? 32'd3 : 32'd0);
    end
    chk("t2_sweep_cnt", {16'd0, sweep_cnt}, 32'd7);

    // Test 3: early retrigger
    cfg_decim = 8'd0; cfg_start = 16'd0; cfg_len = 16'd100;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t3_hdr1", out_word, 32'hA000_0001);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 0, 1, 32'h3000_0000 + k);
      if (out_valid && out_word == 32'h3000_0000 + k) n++;
    end
    chk("t3_fwd_count", n, 32'd20);
    cyc(1, 1, 0, 0, 1, 32'hBAD0_BAD0);
    chk("t3_hdr2_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hdr2", out_word, 32'hA000_0002);
    chk("t3_trunc", {24'd0, trunc_cnt}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t3_no_echo", {31'd0, out_valid}, 32'd0);

    // Test 4: azimuth with hm beating bi
    rst_n = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cfg_len = 16'd0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
    end
    cyc(1, 1, 0, 0, 0, 0);
    chk("t4_hdr", out_word, 32'hA002_0001);

    // Test 5: zero-length window, then arm dropped mid-window
    chk("t5_len0_busy", {31'd0, busy}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t5_len0_hdr2", out_word, 32'hA002_0002);
    cfg_start = 16'd1; cfg_len = 16'd3;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t5_hdr3", out_word, 32'hA002_0003);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 1, 32'h5000_0000 + k);
      if (out_valid) n++;
    end
    chk("t5_fwd_count", n, 32'd3);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t5_idle_trg", {31'd0, out_valid}, 32'd0);
    chk("t5_idle_sweep", {16'd0, sweep_cnt}, 32'd3);

    // Test 6: reset mid-capture
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t6_hdr_pre", out_word, 32'hA002_0001);
    cyc(1, 0, 0, 0, 1, 32'h6000_0000);
    cyc(1, 0, 0, 0, 1, 32'h6000_0001);
    chk("t6_fwd", out_word, 32'h6000_0001);
    rst_n = 1'b0;
    cyc(1, 0, 0, 0, 1, 32'h6000_0002);
    rst_n = 1'b1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_word", out_word, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_sweep", {16'd0, sweep_cnt}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t6_hdr_post", out_word, 32'hA000_0001);
    chk("t6_hdr_valid", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sweep_capture_ctrl.md
Name: sweep_capture_ctrl

Overview:
Sequences radar sweep capture between the CFAR/packing datapath and the Nios PIO sampler. It detects sweep triggers and counts range bins on the packed-word stream. It forwards only a configured range window on every (decim+1)-th sweep and prefixes each captured sweep with a header word carrying sweep and azimuth counts. It sits in the clk_sampling domain, between the word packer output (word + valid) and the PIO sampler input (PIO_INPUT / PIO_INPUT_VALID).

Parameters:
WORD_W, 32, width of the data and header words.
CNT_W, 16, width of the range-bin, window-start and window-length counters.
AZ_W, 12, width of the azimuth (bearing-increment) counter.
DEC_W, 8, width of the sweep decimation counter.

Ports:
clk  in  1  sampling clock, single domain.
rst_n  in  1  synchronous reset, active low.
arm  in  1  level; capture enabled while high (switch or host driven, already synchronized).
trg  in  1  sweep trigger level, synchronized; the rising edge starts a sweep.
hm  in  1  heading marker level; the rising edge clears the azimuth count.
bi  in  1  bearing increment level; the rising edge increments the azimuth count.
in_word  in  WORD_W  packed word from the packer.
in_valid  in  1  one-cycle qualifier for in_word.
cfg_start  in  CNT_W  first range bin forwarded.
cfg_len  in  CNT_W  number of bins forwarded per captured sweep.
cfg_decim  in  DEC_W  sweeps skipped between captures (0 = capture every sweep).
out_word  out  WORD_W  word to the PIO sampler.
out_valid  out  1  one-cycle qualifier for out_word.
busy  out  1  high in the CAPTURE state.
sweep_cnt  out  CNT_W  triggers seen since arm; wraps.
trunc_cnt  out  8  captured sweeps cut short by an early trigger; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State is IDLE.
  - out_word=0, out_valid=0, busy=0, sweep_cnt=0, trunc_cnt=0.
  - Azimuth count, decimation counter and bin counter are 0.
  - Edge-detect history registers are 0.
  - Reset has priority over all other events, including mid-capture; a partial sweep is abandoned with no trailing output.
- Edge detection: trg, hm and bi are each registered once; an edge is cur=1 and prev=0. Edge events take effect in the cycle they are detected.
- Azimuth count:
  - Cleared on an hm edge; incremented (wrapping) on a bi edge.
  - If both edges occur in the same cycle, hm wins and the count becomes 0.
  - The count runs in every state, independent of arm.
- States:
  - IDLE: outputs idle. Go to WAIT_TRG when arm=1.
  - WAIT_TRG: on a trg edge, increment sweep_cnt and latch cfg_start, cfg_len and cfg_decim into shadow registers. If the decimation counter is 0, go to CAPTURE; otherwise decrement it and go to SKIP.
  - CAPTURE:
    - Entry cycle (the trg-edge cycle): out_valid=1, out_word={4'hA, az[11:0], sweep_cnt_new[15:0]}. Reload the decimation counter with shadow decim. Clear the bin counter.
    - From the next cycle, each in_valid increments the bin counter. The word is forwarded (out_word=in_word, out_valid=1, registered, 1-cycle latency) when start <= bin < start+len.
    - The window sum is computed at CNT_W+1 bits, so there is no wrap.
    - in_valid in the trg-edge cycle is ignored and not counted.
    - After the last window word is forwarded (or in the entry cycle if len=0), go to WAIT_TRG, or to IDLE if arm=0.
  - SKIP: no output. On the next trg edge, act exactly as WAIT_TRG. If arm=0, go to IDLE.
- Early trigger in CAPTURE (trg edge before the window completes):
  - The current sweep ends and trunc_cnt increments.
  - The same cycle is treated as a WAIT_TRG trigger. A header is emitted if the new sweep is captured.
- arm=0 in CAPTURE: the current window is completed first, then the block goes to IDLE. arm=0 in WAIT_TRG: go to IDLE next cycle.
- Re-arm from IDLE:
  - sweep_cnt and trunc_cnt are cleared and the decimation counter is set to 0, so the first sweep after arm is captured.
  - The azimuth count is not cleared.
- At most one output word per cycle. Header and data can never coincide because trigger-cycle input is discarded.
- out_valid is never high in IDLE, WAIT_TRG or SKIP, except for the header in the trigger cycle.
- busy=1 exactly while the state is CAPTURE, including the header cycle.

Test Plan:
1. Reset, arm=1, cfg_start=3, cfg_len=4, cfg_decim=0; trigger, then 10 in_valid words D0..D9 -> header 0xA000_0001, then exactly D3..D6 with out_valid one cycle after each input; busy drops after D6.
2. cfg_decim=2; 7 triggers with 8 words each -> headers carry sweep_cnt 1, 4, 7 only; no output on sweeps 2, 3, 5, 6.
3. cfg_start=0, cfg_len=100; retrigger after 20 words -> trunc_cnt=1, new header 0xA000_0002; D0..D19 of sweep 1 forwarded; in_valid in the retrigger cycle is not output.
4. 5 bi edges, then hm and bi edges in the same cycle, then 2 bi edges, then trigger -> header bits [27:16]=0x002.
5. cfg_len=0 -> header only, immediate return to WAIT_TRG; arm dropped mid-window -> window finishes, then IDLE; later triggers produce no output.
6. rst_n=0 for one cycle mid-capture -> next cycle all outputs 0, state IDLE; subsequent arm and trigger gives header sweep_cnt=1.
